// File: rtl/mmx_scoreboard.sv
// Pending-write scoreboard for the eight MMX registers: counts issued-but-not-written-back
// writes per register and stalls decode on RAW hazards or a full destination counter.
// Optional build macro MMX_WB_BYPASS_EN: hazard checks see this cycle's writeback (0-cycle release).
module mmx_scoreboard #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned NUM_MM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_v,
  input  logic       mm1_needed,
  input  logic       mm2_needed,
  input  logic [2:0] mm1,
  input  logic [2:0] mm2,
  input  logic       ld_mm,
  input  logic [2:0] dmm,
  input  logic       wb_v,
  input  logic [2:0] wb_mm,
  input  logic       flush,
  output logic       stall,
  output logic       issue_ack,
  output logic [7:0] busy_vec,
  output logic       wb_err
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntZero = '0;
  localparam logic [CNT_W-1:0] CntOne  = CntZero + 1'b1;

  logic [CNT_W-1:0]  cnt_q   [NUM_MM];
  logic [CNT_W-1:0]  cnt_d   [NUM_MM];
  logic [CNT_W-1:0]  cnt_eff [NUM_MM];
  logic [NUM_MM-1:0] inc, dec;
  logic [NUM_MM-1:0] busy_q, busy_d;
  logic              wb_err_q, wb_err_d;
  logic              src1_haz, src2_haz, dst_full;

  // Decrement is guarded so a stray writeback can never underflow a counter.
  always_comb begin
    for (int i = 0; i < NUM_MM; i++) begin
      dec[i] = wb_v & (wb_mm == 3'(i)) & (cnt_q[i] != CntZero);
`ifdef MMX_WB_BYPASS_EN
      cnt_eff[i] = dec[i] ? cnt_q[i] - CntOne : cnt_q[i];
`else
      cnt_eff[i] = cnt_q[i];
`endif
    end
  end

  // Hazards use pre-flush state even when a flush is present.
  always_comb begin
    src1_haz  = mm1_needed & (cnt_eff[mm1] != CntZero);
    src2_haz  = mm2_needed & (cnt_eff[mm2] != CntZero);
    dst_full  = ld_mm & (cnt_eff[dmm] == CntMax);
    stall     = issue_v & (src1_haz | src2_haz | dst_full);
    issue_ack = issue_v & ~stall;
  end

  always_comb begin
    for (int i = 0; i < NUM_MM; i++) begin
      inc[i]   = issue_ack & ld_mm & (dmm == 3'(i));
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = CntZero;
      end else if (inc[i] & ~dec[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec[i] & ~inc[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      busy_d[i] = (cnt_d[i] != CntZero);
    end
    // A flush discards the same-cycle writeback, including its error check.
    wb_err_d = wb_err_q | (~flush & wb_v & (cnt_q[wb_mm] == CntZero));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MM; i++) cnt_q[i] <= CntZero;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MM; i++) cnt_q[i] <= cnt_d[i];
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule
